// File: rtl/sci_pkt_fifo_v2.sv
// Synchronous packet FIFO carrying {data, mode, result} words, with simultaneous push/pop,
// any depth >= 2, optional first-word-fall-through output, threshold flags and sticky errors.
module sci_pkt_fifo_v2 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_MODES  = 4,
  parameter int unsigned RES_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_THRESH  = 12,
  parameter int unsigned AE_THRESH  = 2,
  parameter int unsigned FWFT       = 1,
  localparam int unsigned W  = DATA_WIDTH + NUM_MODES + RES_WIDTH,
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1),
  localparam int unsigned PW = $clog2(FIFO_DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          EN,
  input  logic          Flush,
  input  logic          ClrErr,
  input  logic          WR,
  input  logic [W-1:0]  dataIn,
  input  logic          RD,
  output logic [W-1:0]  dataOut,
  output logic          dataValid,
  output logic [CW-1:0] COUNT,
  output logic          EMPTY,
  output logic          FULL,
  output logic          ALMOST_FULL,
  output logic          ALMOST_EMPTY,
  output logic          OVF,
  output logic          UDF
);

  if (FIFO_DEPTH < 2) begin : g_chk_depth
    $error("sci_pkt_fifo_v2: FIFO_DEPTH must be >= 2");
  end
  if (AF_THRESH > FIFO_DEPTH) begin : g_chk_af
    $error("sci_pkt_fifo_v2: AF_THRESH must be <= FIFO_DEPTH");
  end
  if (AE_THRESH >= FIFO_DEPTH) begin : g_chk_ae
    $error("sci_pkt_fifo_v2: AE_THRESH must be < FIFO_DEPTH");
  end

  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          empty, full, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));

  // Flush masks the strobes so a flushed cycle neither moves data nor raises errors.
  assign pop  = EN & RD & ~empty & ~Flush;
  assign push = EN & WR & (~full | pop) & ~Flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (Flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
    // A fresh error outranks a simultaneous clear.
    ovf_d = (ovf_q & ~ClrErr) | (EN & WR & full & ~pop & ~Flush);
    udf_d = (udf_q & ~ClrErr) | (EN & RD & empty & ~Flush);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst && push) mem_q[wr_ptr_q] <= dataIn;
  end

  if (FWFT != 0) begin : g_fwft
    assign dataValid = ~empty;
    assign dataOut   = empty ? '0 : mem_q[rd_ptr_q];
  end else begin : g_reg_rd
    logic [W-1:0] dout_q, dout_d;
    logic         dvalid_q, dvalid_d;

    // The array read sees pre-edge contents, so a same-address write returns old data.
    always_comb begin
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      if (pop) begin
        dout_d   = mem_q[rd_ptr_q];
        dvalid_d = 1'b1;
      end
    end

    always_ff @(posedge Clk) begin
      if (!Rst) begin
        dout_q   <= '0;
        dvalid_q <= 1'b0;
      end else begin
        dout_q   <= dout_d;
        dvalid_q <= dvalid_d;
      end
    end

    assign dataOut   = dout_q;
    assign dataValid = dvalid_q;
  end

  assign COUNT        = count_q;
  assign EMPTY        = empty;
  assign FULL         = full;
  assign ALMOST_FULL  = (count_q >= CW'(AF_THRESH));
  assign ALMOST_EMPTY = (count_q <= CW'(AE_THRESH));
  assign OVF          = ovf_q;
  assign UDF          = udf_q;

endmodule

// File: tb/tb_sci_pkt_fifo_v2.sv
// Scoreboard bench: three FIFO configurations share one stimulus stream and are checked
// against a list-based reference model every cycle.
module tb_sci_pkt_fifo_v2;
  localparam int unsigned W = 24;

  logic         Clk = 1'b0;
  logic         Rst, EN, Flush, ClrErr, WR, RD;
  logic [W-1:0] dataIn;

  logic [W-1:0] o_dout [3];
  logic         o_dv [3], o_emp [3], o_full [3], o_af [3], o_ae [3], o_ovf [3], o_udf [3];
  logic [4:0]   cnt0;
  logic [2:0]   cnt1, cnt2;

  always #5 Clk = ~Clk;

  sci_pkt_fifo_v2 #(.DATA_WIDTH(16), .NUM_MODES(4), .RES_WIDTH(4), .FIFO_DEPTH(16),
                    .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u_f16 (
    .Clk(Clk), .Rst(Rst), .EN(EN), .Flush(Flush), .ClrErr(ClrErr), .WR(WR), .dataIn(dataIn),
    .RD(RD), .dataOut(o_dout[0]), .dataValid(o_dv[0]), .COUNT(cnt0), .EMPTY(o_emp[0]),
    .FULL(o_full[0]), .ALMOST_FULL(o_af[0]), .ALMOST_EMPTY(o_ae[0]), .OVF(o_ovf[0]), .UDF(o_udf[0]));

  sci_pkt_fifo_v2 #(.DATA_WIDTH(16), .NUM_MODES(4), .RES_WIDTH(4), .FIFO_DEPTH(5),
                    .AF_THRESH(4), .AE_THRESH(1), .FWFT(1)) u_f5 (
    .Clk(Clk), .Rst(Rst), .EN(EN), .Flush(Flush), .ClrErr(ClrErr), .WR(WR), .dataIn(dataIn),
    .RD(RD), .dataOut(o_dout[1]), .dataValid(o_dv[1]), .COUNT(cnt1), .EMPTY(o_emp[1]),
    .FULL(o_full[1]), .ALMOST_FULL(o_af[1]), .ALMOST_EMPTY(o_ae[1]), .OVF(o_ovf[1]), .UDF(o_udf[1]));

  sci_pkt_fifo_v2 #(.DATA_WIDTH(16), .NUM_MODES(4), .RES_WIDTH(4), .FIFO_DEPTH(6),
                    .AF_THRESH(5), .AE_THRESH(1), .FWFT(0)) u_r6 (
    .Clk(Clk), .Rst(Rst), .EN(EN), .Flush(Flush), .ClrErr(ClrErr), .WR(WR), .dataIn(dataIn),
    .RD(RD), .dataOut(o_dout[2]), .dataValid(o_dv[2]), .COUNT(cnt2), .EMPTY(o_emp[2]),
    .FULL(o_full[2]), .ALMOST_FULL(o_af[2]), .ALMOST_EMPTY(o_ae[2]), .OVF(o_ovf[2]), .UDF(o_udf[2]));

  function automatic int dep(int i);  return (i == 0) ? 16 : (i == 1) ? 5 : 6; endfunction
  function automatic int afth(int i); return (i == 0) ? 12 : (i == 1) ? 4 : 5; endfunction
  function automatic int aeth(int i); return (i == 0) ? 2 : 1; endfunction
  function automatic bit fw(int i);   return (i != 2); endfunction

  // Reference model: an ordered list per instance, head at index 0.
  logic [W-1:0] m_list [3][16];
  int           m_cnt [3];
  bit           m_ovf [3], m_udf [3], m_dv [3];
  logic [W-1:0] m_dout [3];

  typedef struct {
    int           inst;
    int           cnt;
    bit           ovf;
    bit           udf;
    bit           dv;
    logic [W-1:0] dout;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string nm, int inst, int act, int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", nm, inst, $time, act, expv);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      if (!Rst) begin
        m_cnt[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_dv[i] = 0; m_dout[i] = '0;
      end else begin
        bit nov, nud;
        nov = ClrErr ? 1'b0 : m_ovf[i];
        nud = ClrErr ? 1'b0 : m_udf[i];
        if (Flush) begin
          m_cnt[i] = 0;
          m_dv[i]  = 0;
        end else if (EN) begin
          bit is_full, is_empty, do_pop, do_push;
          is_full  = (m_cnt[i] == dep(i));
          is_empty = (m_cnt[i] == 0);
          do_pop   = RD && !is_empty;
          do_push  = WR && (!is_full || do_pop);
          if (WR && is_full && !do_pop) nov = 1;
          if (RD && is_empty) nud = 1;
          if (do_pop) begin
            if (!fw(i)) begin
              m_dout[i] = m_list[i][0];
            end
            for (int k = 0; k < 15; k++) m_list[i][k] = m_list[i][k+1];
            m_cnt[i]--;
          end
          m_dv[i] = do_pop;
          if (do_push) begin
            m_list[i][m_cnt[i]] = dataIn;
            m_cnt[i]++;
          end
        end else begin
          m_dv[i] = 0;
        end
        m_ovf[i] = nov;
        m_udf[i] = nud;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.inst = i;
      e.cnt  = m_cnt[i];
      e.ovf  = m_ovf[i];
      e.udf  = m_udf[i];
      e.dv   = fw(i) ? (m_cnt[i] != 0) : m_dv[i];
      e.dout = fw(i) ? m_list[i][0] : m_dout[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic drive(bit wr, bit rd, logic [W-1:0] d);
    WR = wr; RD = rd; dataIn = d;
    tick();
  endtask

  // Monitor: compare each queued expectation against the presented outputs.
  initial begin
    exp_t e;
    int   act_cnt;
    forever begin
      @(negedge Clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act_cnt = (e.inst == 0) ? int'(cnt0) : (e.inst == 1) ? int'(cnt1) : int'(cnt2);
        check("count", e.inst, act_cnt, e.cnt);
        check("empty", e.inst, int'(o_emp[e.inst]), int'(e.cnt == 0));
        check("full", e.inst, int'(o_full[e.inst]), int'(e.cnt == dep(e.inst)));
        check("almost_full", e.inst, int'(o_af[e.inst]), int'(e.cnt >= afth(e.inst)));
        check("almost_empty", e.inst, int'(o_ae[e.inst]), int'(e.cnt <= aeth(e.inst)));
        check("ovf", e.inst, int'(o_ovf[e.inst]), int'(e.ovf));
        check("udf", e.inst, int'(o_udf[e.inst]), int'(e.udf));
        check("data_valid", e.inst, int'(o_dv[e.inst]), int'(e.dv));
        if (!fw(e.inst) || e.dv)
          check("data_out", e.inst, int'(o_dout[e.inst]), int'(e.dout));
      end
      check("ptr_bound_d5", 1, int'(u_f5.rd_ptr_q <= 3'd4 && u_f5.wr_ptr_q <= 3'd4), 1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    Rst = 1'b0; EN = 1'b1; Flush = 1'b0; ClrErr = 1'b0; WR = 1'b0; RD = 1'b0; dataIn = '0;
    #1;
    tick(); tick();
    Rst = 1'b1;
    drive(0, 0, '0);

    // Fill and drain in order; smaller instances overflow then underflow.
    for (int i = 0; i < 16; i++) drive(1, 0, W'(i));
    for (int i = 0; i < 17; i++) drive(0, 1, '0);
    ClrErr = 1'b1; drive(0, 0, '0); ClrErr = 1'b0;

    // Simultaneous push/pop while full, then while empty.
    for (int i = 0; i < 16; i++) drive(1, 0, W'($urandom));
    drive(1, 1, W'($urandom));
    drive(0, 0, '0);
    for (int i = 0; i < 16; i++) drive(0, 1, '0);
    ClrErr = 1'b1; drive(0, 0, '0); ClrErr = 1'b0;
    drive(1, 1, 24'h123456);
    drive(0, 0, '0);

    // Sticky errors, clear, and EN=0 suppression.
    for (int i = 0; i < 16; i++) drive(1, 0, W'($urandom));
    drive(1, 0, 24'hBAD);
    for (int i = 0; i < 10; i++) drive(0, 0, '0);
    ClrErr = 1'b1; drive(0, 0, '0); ClrErr = 1'b0;
    ClrErr = 1'b1; drive(1, 0, 24'hBAD); ClrErr = 1'b0;
    ClrErr = 1'b1; drive(0, 0, '0); ClrErr = 1'b0;
    EN = 1'b0; drive(1, 0, 24'hBAD); drive(0, 1, '0); EN = 1'b1;
    for (int i = 0; i < 17; i++) drive(0, 1, '0);
    drive(0, 0, '0);
    ClrErr = 1'b1; drive(0, 0, '0); ClrErr = 1'b0;

    // Flush outranks a same-cycle push/pop.
    for (int i = 0; i < 7; i++) drive(1, 0, W'($urandom));
    Flush = 1'b1; drive(1, 1, 24'hF00); Flush = 1'b0;
    drive(0, 0, '0);

    // Reset acts even with EN low.
    for (int i = 0; i < 3; i++) drive(1, 0, W'($urandom));
    drive(0, 1, '0);
    EN = 1'b0; Rst = 1'b0; drive(1, 1, 24'h77); Rst = 1'b1; EN = 1'b1;
    drive(0, 0, '0);

    // Registered-read latency.
    drive(1, 0, 24'h0000A5);
    drive(0, 1, '0);
    drive(0, 0, '0);
    drive(0, 0, '0);

    // Random traffic with occasional stalls, flushes and clears.
    for (int i = 0; i < 200; i++) begin
      EN     = ($urandom_range(0, 7) != 0);
      Flush  = ($urandom_range(0, 39) == 0);
      ClrErr = ($urandom_range(0, 19) == 0);
      drive(1'($urandom), 1'($urandom), W'($urandom));
    end
    EN = 1'b1; Flush = 1'b0; ClrErr = 1'b0;
    drive(0, 0, '0);

    @(negedge Clk);
    #1;
    check("scoreboard_drained", 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
